// File: rtl/fetch_controller.sv
// fetch_controller: 6502 fetch sequencer (PC, fetch read port, opcode/operand bundling, redirects).
// Define RESET_VECTOR_FETCH_EN to load the start PC from the reset vector at RESET_PC/RESET_PC+1.
module fetch_controller #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ack,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [REG_WIDTH-1:0]  instr_opcode,
    output logic [REG_WIDTH-1:0]  instr_op_lo,
    output logic [REG_WIDTH-1:0]  instr_op_hi,
    output logic [1:0]            instr_len,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_illegal,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  busy
);
    typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, PRESENT} state_t;
`ifdef RESET_VECTOR_FETCH_EN
    localparam state_t START = VEC_LO;
`else
    localparam state_t START = FETCH_OP;
`endif

    // returns {illegal, len[1:0]} from the aaabbbcc opcode layout
    function automatic logic [2:0] decode(input logic [7:0] op);
        logic [2:0] a, b;
        a = op[7:5];
        b = op[4:2];
        case (op[1:0])
            2'b01:   return {1'b0, (b == 3'd3 || b >= 3'd6) ? 2'd2 : 2'd1};
            2'b10:   return {1'b0, (b == 3'd3 || b == 3'd7) ? 2'd2 :
                                   (b == 3'd0 || b == 3'd1 || b == 3'd5) ? 2'd1 : 2'd0};
            2'b00:   return {1'b0, (op == 8'h20 || op == 8'h4C || op == 8'h6C || b == 3'd3 || b == 3'd7) ? 2'd2 :
                                   (b == 3'd4 || b == 3'd1 || b == 3'd5 || (b == 3'd0 && a >= 3'd5)) ? 2'd1 : 2'd0};
            default: return 3'b100;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d, ipc_b_q, ipc_b_d, ipc_q, ipc_d;
    logic [REG_WIDTH-1:0]  op_b_q, op_b_d, lo_b_q, lo_b_d;
    logic [REG_WIDTH-1:0]  opcode_q, opcode_d, op_lo_q, op_lo_d, op_hi_q, op_hi_d;
    logic [1:0]            len_q, len_d;
    logic                  up_q, pend_q, pend_d, valid_q, valid_d, ill_q, ill_d;
    logic                  ack, vec;
    logic [REG_WIDTH-1:0]  cur_op;
    logic [2:0]            dec;

    // up_q keeps every output low during reset and the first cycle after release
    assign mem_req       = up_q && state_q != PRESENT;
    assign mem_addr      = mem_req ? pc_q : '0;
    assign busy          = mem_req;
    assign ack           = mem_req && mem_ack;
    assign vec           = state_q == VEC_LO || state_q == VEC_HI;
    assign cur_op        = state_q == FETCH_OP ? mem_rdata : op_b_q;
    assign dec           = decode(cur_op[7:0]);
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_op_lo   = op_lo_q;
    assign instr_op_hi   = op_hi_q;
    assign instr_len     = len_q;
    assign instr_pc      = ipc_q;
    assign instr_illegal = ill_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        op_b_d      = op_b_q;
        lo_b_d      = lo_b_q;
        ipc_b_d     = ipc_b_q;
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        op_lo_d     = op_lo_q;
        op_hi_d     = op_hi_q;
        len_d       = len_q;
        ipc_d       = ipc_q;
        ill_d       = ill_q;
        if (ack) begin
            pc_d = pc_q + 1'b1;
            case (state_q)
                VEC_LO:   begin lo_b_d = mem_rdata; state_d = VEC_HI; end
                VEC_HI:   begin pc_d = ADDR_WIDTH'({mem_rdata, lo_b_q}); state_d = FETCH_OP; end
                FETCH_OP: begin op_b_d = mem_rdata; ipc_b_d = pc_q; state_d = dec[1:0] == 2'd0 ? PRESENT : FETCH_LO; end
                FETCH_LO: begin lo_b_d = mem_rdata; state_d = dec[1:0] == 2'd1 ? PRESENT : FETCH_HI; end
                default:  state_d = PRESENT;
            endcase
        end
        if (state_q == PRESENT && instr_ready) begin
            valid_d = 1'b0;
            state_d = FETCH_OP;
        end
        // an outstanding read must complete, so a mid-request redirect is parked until its ack
        if (redirect_valid && !vec) begin
            if (!mem_req || ack) begin
                pc_d    = redirect_addr;
                state_d = FETCH_OP;
                valid_d = 1'b0;
                pend_d  = 1'b0;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = redirect_addr;
            end
        end else if (pend_q && ack) begin
            pc_d    = pend_addr_q;
            state_d = FETCH_OP;
            pend_d  = 1'b0;
        end
        if (state_d == PRESENT && state_q != PRESENT) begin
            valid_d  = 1'b1;
            opcode_d = cur_op;
            ipc_d    = state_q == FETCH_OP ? pc_q : ipc_b_q;
            op_lo_d  = state_q == FETCH_LO ? mem_rdata : state_q == FETCH_HI ? lo_b_q : '0;
            op_hi_d  = state_q == FETCH_HI ? mem_rdata : '0;
            len_d    = dec[1:0];
            ill_d    = dec[2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= START;
            pc_q        <= RESET_PC;
            up_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            op_b_q      <= '0;
            lo_b_q      <= '0;
            ipc_b_q     <= '0;
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            op_lo_q     <= '0;
            op_hi_q     <= '0;
            len_q       <= '0;
            ipc_q       <= '0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            up_q        <= 1'b1;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            op_b_q      <= op_b_d;
            lo_b_q      <= lo_b_d;
            ipc_b_q     <= ipc_b_d;
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            op_lo_q     <= op_lo_d;
            op_hi_q     <= op_hi_d;
            len_q       <= len_d;
            ipc_q       <= ipc_d;
            ill_q       <= ill_d;
        end
    end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Instruction fetch sequencer in front of the decoder. Owns the program counter and the single memory read port used for fetch. It fetches the opcode byte, derives the operand byte count from the 6502 aaabbbcc encoding, fetches 0-2 operand bytes, and presents a complete instruction bundle to the decoder with a valid/ready handshake. It accepts PC redirects from the execute stage for branches, jumps and interrupts.

Parameters:
REG_WIDTH, 8, data byte width
ADDR_WIDTH, 16, address and PC width
RESET_PC, 16'hFFFC, reset vector address, or start PC when vector fetch is compiled out

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mem_req  out  1  read request; held until mem_ack
mem_addr  out  ADDR_WIDTH  read address; stable while mem_req=1
mem_rdata  in  REG_WIDTH  read data; valid in the mem_ack cycle
mem_ack  in  1  read completes this cycle; ignored when mem_req=0
instr_valid  out  1  instruction bundle valid
instr_ready  in  1  decoder accepts bundle
instr_opcode  out  REG_WIDTH  opcode byte
instr_op_lo  out  REG_WIDTH  first operand byte; 0 if absent
instr_op_hi  out  REG_WIDTH  second operand byte; 0 if absent
instr_len  out  2  operand byte count, 0-2
instr_pc  out  ADDR_WIDTH  address of the opcode byte
instr_illegal  out  1  opcode has cc=11; presented with len 0
redirect_valid  in  1  load a new PC, single-cycle pulse
redirect_addr  in  ADDR_WIDTH  new PC
busy  out  1  high in every state except PRESENT

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, pc=RESET_PC, state=VEC_LO (or FETCH_OP with the feature compiled out). Reset mid-transaction abandons it; a late mem_ack is ignored.
- States: VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, PRESENT.
- Every fetch state asserts mem_req with mem_addr=pc. On mem_ack, the byte is latched, pc=pc+1 (wraps 16'hFFFF->16'h0000), and the FSM advances. Without mem_ack the FSM holds, min 1 cycle per byte.
- VEC_LO/VEC_HI: read RESET_PC, then RESET_PC+1. pc={hi,lo}. Then FETCH_OP.
- FETCH_OP: latch opcode and instr_pc, compute len. len=0 -> PRESENT; otherwise -> FETCH_LO.
- FETCH_LO: len=1 -> PRESENT; len=2 -> FETCH_HI. FETCH_HI -> PRESENT.
- Length rules, opcode aaabbbcc:
  - cc=01: bbb 011/110/111 -> 2; all others -> 1.
  - cc=10: bbb 000/001/101 -> 1; 011/111 -> 2; 010/100/110 -> 0.
  - cc=00: opcodes 20/4C/6C -> 2; bbb=100 (branches) -> 1; bbb=000 with aaa>=101 -> 1; bbb 001/101 -> 1; bbb 011/111 -> 2; everything else -> 0.
  - cc=11: len 0, instr_illegal=1.
- PRESENT: instr_valid=1 and all bundle outputs held stable until instr_ready=1. On handshake: instr_valid=0 next cycle, -> FETCH_OP. Bundle outputs update only on entry to PRESENT.
- Redirect:
  - With no outstanding request, or in PRESENT: pc=redirect_addr next cycle, instr_valid drops, -> FETCH_OP. If instr_ready is high in the same cycle, the handshake completes and the bundle counts as consumed.
  - During a fetch state with mem_req=1 and no mem_ack: finish the transaction (mem_addr held), discard the data, then load redirect_addr. Redirect is recorded in a pending flag. A second redirect before completion overwrites the pending address.
  - Redirect in the same cycle as mem_ack: data discarded, pc=redirect_addr, -> FETCH_OP.
  - Redirect during VEC_LO/VEC_HI is ignored.
- mem_req never drops before mem_ack, except under reset.

Optional Feature:
RESET_VECTOR_FETCH_EN: when defined, reset enters VEC_LO and loads pc from memory at RESET_PC/RESET_PC+1. When undefined, VEC states are absent and reset enters FETCH_OP with pc=RESET_PC.

Test Plan:
- Vector fetch: mem[FFFC]=00, mem[FFFD]=80 -> first instr_pc=16'h8000.
- Length decode: A9 44 (LDA #) -> len 1, op_lo=44. AD 34 12 -> len 2, op_lo=34, op_hi=12. EA -> len 0. 6C -> len 2. 03 -> illegal=1, len 0. Next instr_pc advances by len+1 each time.
- Backpressure: hold instr_ready=0 for 5 cycles -> bundle stable, mem_req=0, busy=0. Release -> next fetch at pc+len+1.
- Memory wait: mem_ack delayed 3 cycles on each byte of AD 34 12 -> mem_addr stable while waiting; bundle presented after the third ack.
- Redirect mid-fetch: redirect_addr=16'h9000 while a FETCH_LO request is outstanding -> request completes, data discarded, next mem_addr=9000, no bundle for the aborted instruction.
- Wrap and reset: opcode EA at FFFF -> next fetch at 0000. Assert reset_n=0 mid-request -> mem_req=0 and instr_valid=0 immediately.
